logisim_tick_controller: RTL and testbench



---
 rtl/logisim_tick_pkg.sv | 14 +
 rtl/logisim_tick_divider.sv | 30 +++
 rtl/logisim_tick_controller.sv | 99 +++++++++
 tb/tb_logisim_tick_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logisim_tick_pkg.sv
// Shared types and helpers for the tick controller: run/stop state and the
// divisor clamp that treats a zero divisor as one.
package logisim_tick_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } tick_state_t;

    function automatic logic [31:0] max1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/logisim_tick_divider.sv
// Reloadable down-counter: reloads on an explicit load or when it expires while
// enabled, otherwise counts down while enabled.
module logisim_tick_divider #(
    parameter int                   NrOfBits = 16,
    parameter logic [NrOfBits-1:0]  ResetCnt = '0
) (
    input  logic                GlobalClock,
    input  logic                Reset,
    input  logic                load,
    input  logic                en,
    input  logic [NrOfBits-1:0] reload_val,
    output logic                zero,
    output logic [NrOfBits-1:0] cnt
);

    assign zero = (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, regardless of statement or process order.
    always_ff @(posedge GlobalClock) begin
        if (Reset) begin
            cnt <= ResetCnt;
        end else if (load || (en && zero)) begin
            cnt <= reload_val;
        end else if (en) begin
            cnt <= cnt - NrOfBits'(1);
        end
    end

endmodule

// File: rtl/logisim_tick_controller.sv
// Generates the one-cycle ClockTick enable for the derived-clock component,
// with run/stop, single-step, a runtime-loadable divisor and a tick counter.
module logisim_tick_controller
    import logisim_tick_pkg::*;
#(
    parameter int NrOfBits     = 16,
    parameter int ReloadValue  = 4,
    parameter int CountBits    = 32,
    parameter bit StartRunning = 1'b0
) (
    input  logic                 GlobalClock,
    input  logic                 Reset,
    input  logic                 RunEnable,
    input  logic                 StepReq,
    input  logic                 DivLoad,
    input  logic [NrOfBits-1:0]  DivValue,
    output logic                 ClockTick,
    output logic                 StepAck,
    output logic                 Running,
    output logic [CountBits-1:0] TickCount
);

    localparam logic [NrOfBits-1:0] ResetDiv   = NrOfBits'(max1(32'(ReloadValue)));
    localparam tick_state_t         ResetState = StartRunning ? RUN : STOP;

    tick_state_t         state_q, state_d;
    logic [NrOfBits-1:0] div_q, div_eff;
    logic [NrOfBits-1:0] cnt;
    logic                cnt_zero, cnt_load, cnt_en;
    logic                tick_d, ack_d;
    logic                unused_cnt;

    // A same-edge load already governs a reload happening on that edge.
    assign div_eff    = DivLoad ? NrOfBits'(max1(32'(DivValue))) : div_q;
    assign Running    = (state_q == RUN);
    assign unused_cnt = ^cnt;

    logisim_tick_divider #(
        .NrOfBits (NrOfBits),
        .ResetCnt (ResetDiv - NrOfBits'(1))
    ) u_divider (
        .GlobalClock (GlobalClock),
        .Reset       (Reset),
        .load        (cnt_load),
        .en          (cnt_en),
        .reload_val  (div_eff - NrOfBits'(1)),
        .zero        (cnt_zero),
        .cnt         (cnt)
    );

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        tick_d   = 1'b0;
        ack_d    = 1'b0;
        unique case (state_q)
            STOP: begin
                if (RunEnable) begin
                    state_d  = RUN;
                    cnt_load = 1'b1;
                end else if (StepReq) begin
                    tick_d = 1'b1;
                    ack_d  = 1'b1;
                end
            end
            RUN: begin
                if (!RunEnable) begin
                    state_d = STOP;
                end else begin
                    cnt_en = 1'b1;
                    tick_d = cnt_zero;
                end
            end
            default: state_d = ResetState;
        endcase
    end

    always_ff @(posedge GlobalClock) begin
        if (Reset) begin
            state_q   <= ResetState;
            div_q     <= ResetDiv;
            ClockTick <= 1'b0;
            StepAck   <= 1'b0;
            TickCount <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_eff;
            ClockTick <= tick_d;
            StepAck   <= ack_d;
            if (tick_d) begin
                TickCount <= TickCount + CountBits'(1);
            end
        end
    end

endmodule

// File: tb/tb_logisim_tick_controller.sv
// Checks two controller instances (default build, and a 4-bit-counter build that
// starts running with divisor 0) against an edge-count reference model.
module tb_logisim_tick_controller;

    logic        GlobalClock = 1'b0;
    logic        rst;
    logic        run_en;
    logic        step_req;
    logic        div_load [2];
    logic [15:0] div_value [2];

    logic        tick_a, ack_a, running_a;
    logic [31:0] count_a;
    logic        tick_b, ack_b, running_b;
    logic [3:0]  count_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 GlobalClock = ~GlobalClock;

    logisim_tick_controller dut_a (
        .GlobalClock (GlobalClock),
        .Reset       (rst),
        .RunEnable   (run_en),
        .StepReq     (step_req),
        .DivLoad     (div_load[0]),
        .DivValue    (div_value[0]),
        .ClockTick   (tick_a),
        .StepAck     (ack_a),
        .Running     (running_a),
        .TickCount   (count_a)
    );

    logisim_tick_controller #(
        .NrOfBits     (16),
        .ReloadValue  (0),
        .CountBits    (4),
        .StartRunning (1'b1)
    ) dut_b (
        .GlobalClock (GlobalClock),
        .Reset       (rst),
        .RunEnable   (run_en),
        .StepReq     (step_req),
        .DivLoad     (div_load[1]),
        .DivValue    (div_value[1]),
        .ClockTick   (tick_b),
        .StepAck     (ack_b),
        .Running     (running_b),
        .TickCount   (count_b)
    );

    // Reference model: counts running edges since the last reload and ticks
    // when that count reaches the period latched at the reload.
    bit              m_run    [2];
    int unsigned     m_div    [2];
    int unsigned     m_period [2];
    int unsigned     m_since  [2];
    bit              m_tick   [2];
    bit              m_ack    [2];
    longint unsigned m_count  [2];

    function automatic int unsigned clamp1(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_edge(input int i);
        int unsigned     deff;
        longint unsigned mask;
        mask = (i == 0) ? 64'hFFFF_FFFF : 64'hF;
        if (rst) begin
            m_run[i]    = (i == 1);
            m_div[i]    = (i == 0) ? 4 : 1;
            m_period[i] = m_div[i];
            m_since[i]  = 0;
            m_tick[i]   = 1'b0;
            m_ack[i]    = 1'b0;
            m_count[i]  = 0;
        end else begin
            deff      = div_load[i] ? clamp1(int'(div_value[i])) : m_div[i];
            m_tick[i] = 1'b0;
            m_ack[i]  = 1'b0;
            if (!m_run[i]) begin
                if (run_en) begin
                    m_run[i]    = 1'b1;
                    m_since[i]  = 0;
                    m_period[i] = deff;
                end else if (step_req) begin
                    m_tick[i]  = 1'b1;
                    m_ack[i]   = 1'b1;
                    m_count[i] = (m_count[i] + 1) & mask;
                end
            end else if (!run_en) begin
                m_run[i] = 1'b0;
            end else begin
                m_since[i] = m_since[i] + 1;
                if (m_since[i] >= m_period[i]) begin
                    m_tick[i]   = 1'b1;
                    m_count[i]  = (m_count[i] + 1) & mask;
                    m_since[i]  = 0;
                    m_period[i] = deff;
                end
            end
            m_div[i] = deff;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge GlobalClock);
        model_edge(0);
        model_edge(1);
        #1;
        check("a.ClockTick", tick_a,    m_tick[0]);
        check("a.StepAck",   ack_a,     m_ack[0]);
        check("a.Running",   running_a, m_run[0]);
        check("a.TickCount", count_a,   m_count[0]);
        check("b.ClockTick", tick_b,    m_tick[1]);
        check("b.StepAck",   ack_b,     m_ack[1]);
        check("b.Running",   running_b, m_run[1]);
        check("b.TickCount", count_b,   m_count[1]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".a.tick"},    tick_a,    0);
        check({tag, ".a.ack"},     ack_a,     0);
        check({tag, ".a.running"}, running_a, 0);
        check({tag, ".a.count"},   count_a,   0);
        check({tag, ".b.tick"},    tick_b,    0);
        check({tag, ".b.running"}, running_b, 1);
        check({tag, ".b.count"},   count_b,   0);
    endtask

    initial begin
        int unsigned base;
        int          nt, na;

        rst = 1'b1; run_en = 1'b0; step_req = 1'b0;
        div_load[0] = 1'b0; div_load[1] = 1'b0;
        div_value[0] = '0;  div_value[1] = '0;
        cyc();
        check_reset_values("reset");

        // Free run with the reset divisor of 4; instance b ticks every edge and wraps.
        rst = 1'b0; run_en = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            cyc();
            check("p1.tick", tick_a, (e == 4 || e == 8 || e == 12));
            if (e == 0) check("p1.running", running_a, 1);
        end
        check("p1.count", count_a, 3);

        // Retime to 2 mid-period, then to 0 (continuous ticking).
        for (int e = 13; e <= 27; e++) begin
            div_load[0]  = (e == 14 || e == 21);
            div_value[0] = (e == 14) ? 16'd2 : 16'd0;
            cyc();
            if (e >= 14 && e <= 21) check("p2.retime", tick_a, (e == 16 || e == 18 || e == 20));
            if (e >= 22) check("p2.div0", tick_a, 1);
            if (e == 15) check("p2.wrap", count_b, 0);
        end
        div_load[0] = 1'b0;

        // Stop, then three single-edge step pulses.
        run_en = 1'b0;
        cyc();
        check("p3.stopped", running_a, 0);
        base = count_a;
        nt = 0; na = 0;
        for (int k = 0; k < 6; k++) begin
            step_req = (k % 2 == 0);
            cyc();
            nt += int'(tick_a);
            na += int'(ack_a);
        end
        step_req = 1'b0;
        check("p3.ticks", nt, 3);
        check("p3.acks",  na, 3);
        check("p3.count", count_a, base + 3);

        // Step and run on the same edge: the run transition wins.
        div_load[0] = 1'b1; div_value[0] = 16'd4;
        cyc();
        div_load[0] = 1'b0;
        step_req = 1'b1; run_en = 1'b1;
        cyc();
        check("p4.ack",     ack_a,     0);
        check("p4.tick",    tick_a,    0);
        check("p4.running", running_a, 1);
        step_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("p4.first", tick_a, (k == 4));
        end

        // Divisor 3: drop RunEnable on the edge a tick is due, then resume.
        run_en = 1'b0; div_load[0] = 1'b1; div_value[0] = 16'd3;
        cyc();
        div_load[0] = 1'b0; run_en = 1'b1;
        cyc();
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("p5.tick", tick_a, (k == 3));
        end
        run_en = 1'b0;
        cyc();
        check("p5.no_tick", tick_a,    0);
        check("p5.stopped", running_a, 0);
        run_en = 1'b1;
        for (int r = 0; r <= 3; r++) begin
            cyc();
            check("p5.resume", tick_a, (r == 3));
        end

        // Reset while ticking continuously.
        div_load[0] = 1'b1; div_value[0] = 16'd1;
        cyc();
        div_load[0] = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        check("p6.pre_tick", tick_a, 1);
        rst = 1'b1; div_load[0] = 1'b1; div_value[0] = 16'd7; step_req = 1'b1;
        cyc();
        check_reset_values("p6");
        rst = 1'b0; div_load[0] = 1'b0; step_req = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) run_en = ~run_en;
            step_req     = ($urandom_range(0, 3) == 0);
            div_load[0]  = ($urandom_range(0, 15) == 0);
            div_load[1]  = ($urandom_range(0, 15) == 0);
            div_value[0] = 16'($urandom_range(0, 5));
            div_value[1] = 16'($urandom_range(0, 3));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
